ncl_stage_arbiter: RTL
======================

NCL_STAGE_ARBITER -- requirements
Module: ncl_stage_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles spent waiting in a DATA or NULL phase.
REQ-002 Parameter CNT_W, default 4: width of the phase counter; SHALL satisfy 2**CNT_W > TIMEOUT.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  2  per-requester request level; held high until that requester's done pulse.
REQ-006 vec0  input  4  requester 0 rail pattern {a,b,c,d}, weights 2,2,1,1.
REQ-007 vec1  input  4  requester 1 rail pattern, same encoding.
REQ-008 gnt  output  2  one-hot grant, high from grant cycle through the RESP cycle.
REQ-009 done  output  2  one-cycle completion pulse to the granted requester.
REQ-010 hit  output  1  valid with done: 1 = stage output asserted in DATA phase, 0 = DATA timeout.
REQ-011 stage_in  output  4  rails driven into the shared weighted threshold-gate stage.
REQ-012 stage_y  input  1  asynchronous stage output.
REQ-013 fault  output  1  sticky: stage failed to return to NULL.
REQ-014 fault_clr  input  1  synchronous clear of fault.

Function
REQ-015 stage_y SHALL pass through a 2-flop synchronizer; y_s denotes the synchronized value; FSM decisions use y_s only.
REQ-016 States: IDLE, DATA, NULL, RESP, FAULT.
REQ-017 IDLE: stage_in=0; if any req, grant per round-robin pointer (pointer side if requesting, else the other), latch that vecN, clear counter, go to DATA.
REQ-018 DATA: stage_in=latched vector; y_s=1 -> hit_r=1, clear counter, go to NULL; else counter==TIMEOUT -> hit_r=0, clear counter, go to NULL; else counter+1.
REQ-019 NULL: stage_in=0; y_s=0 -> RESP; else counter==TIMEOUT -> FAULT; else counter+1.
REQ-020 RESP: done[g]=1 and hit=hit_r for exactly one cycle; pointer set to the other requester; go to IDLE.
REQ-021 FAULT: stage_in=0, gnt=0, fault=1, no grants; fault_clr=1 -> IDLE with fault cleared next cycle; granted requester receives no done.
REQ-022 Simultaneous req[0] and req[1] in IDLE: pointer side wins; loser is served on the next grant (no starvation).
REQ-023 req changes during DATA/NULL SHALL be ignored; vector is sampled only on the grant edge.
REQ-024 Minimum transaction with immediate stage response: grant edge to done pulse = 2 sync + 1 DATA + 2 sync + 1 NULL + RESP, i.e. done no earlier than cycle 7 after grant.
REQ-025 Counter SHALL saturate logic-free via state exit; never wraps within a phase.
REQ-026 hit SHALL be 0 whenever done==0.

Reset
REQ-027 rst_n low: state=IDLE, pointer=0, counter=0, synchronizer flops=0, hit_r=0; outputs gnt=0, done=0, hit=0, stage_in=0, fault=0, asynchronously.
REQ-028 Reset mid-transaction SHALL abandon it with no done pulse; stage_in driven to NULL immediately.

Structure
REQ-029 Package ncl_ctrl_pkg SHALL hold the state enum, TIMEOUT/CNT_W defaults and rail-weight constants.
REQ-030 Synchronizer SHALL be sub-module ncl_sync2 (1-bit, clk, rst_n, d, q); remainder single module.

Verification
REQ-031 req=01, vec0=1100, stage model y=1 two cycles after DATA, back to 0 two cycles after NULL -> gnt=01, stage_in=1100 then 0000, done=01 with hit=1.
REQ-032 req=10, vec1=0011 (weight 2 < 4), stage never fires -> stage_in=0011 for TIMEOUT+1 cycles, done=10 with hit=0.
REQ-033 req=11 held continuously, pointer=0 -> grants alternate 01,10,01,10; each done matches its gnt.
REQ-034 stage model holds y=1 after NULL -> fault=1 after TIMEOUT NULL cycles, no done; fault_clr=1 -> IDLE, fault=0, next req granted.
REQ-035 rst_n low during DATA with vec0=1111 -> stage_in=0000, gnt=00 immediately; no done after release.
REQ-036 vec0 changed 1100->0000 during DATA -> stage_in remains 1100 until NULL phase.

Source files
------------

// File: rtl/ncl_ctrl_pkg.sv
// Shared types and constants for the NCL stage arbiter.
// Rails {a,b,c,d} feed a weighted threshold gate (2,2,1,1 / 4).
package ncl_ctrl_pkg;

  localparam int TIMEOUT_DEF = 15;
  localparam int CNT_W_DEF   = 4;

  localparam int W_A    = 2;
  localparam int W_B    = 2;
  localparam int W_C    = 1;
  localparam int W_D    = 1;
  localparam int THRESH = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_NULL,
    S_RESP,
    S_FAULT
  } state_t;

endpackage

// File: rtl/ncl_sync2.sv
// Two-flop synchronizer for the asynchronous stage output.
// Resets to 0 so a reset stage reads as NULL.
module ncl_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ncl_stage_arbiter.sv
// Round-robin arbiter driving one shared NCL threshold stage
// through DATA/NULL phases, with timeout and sticky fault.
module ncl_stage_arbiter
  import ncl_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [3:0] vec0,
  input  logic [3:0] vec1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       hit,
  output logic [3:0] stage_in,
  input  logic       stage_y,
  output logic       fault,
  input  logic       fault_clr
);

  state_t           state, state_nx;
  logic             ptr, ptr_nx;
  logic             gsel, gsel_nx;
  logic             hit_r, hit_nx;
  logic [3:0]       vec_r, vec_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             y_s;
  logic             cnt_max;
  logic             pick;
  logic [1:0]       gsel_oh;

  ncl_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (stage_y),
    .q     (y_s)
  );

  assign cnt_max = (cnt == CNT_W'(TIMEOUT));
  assign pick    = req[ptr] ? ptr : ~ptr;
  assign gsel_oh = {gsel, ~gsel};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= 1'b0;
      gsel  <= 1'b0;
      hit_r <= 1'b0;
      vec_r <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      gsel  <= gsel_nx;
      hit_r <= hit_nx;
      vec_r <= vec_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    gsel_nx  = gsel;
    hit_nx   = hit_r;
    vec_nx   = vec_r;
    cnt_nx   = cnt;
    unique case (state)
      S_IDLE: begin
        if (|req) begin
          gsel_nx  = pick;
          vec_nx   = pick ? vec1 : vec0;
          cnt_nx   = '0;
          state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (y_s) begin
          hit_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = S_NULL;
        end else if (cnt_max) begin
          hit_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = S_NULL;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_NULL: begin
        if (!y_s) begin
          state_nx = S_RESP;
        end else if (cnt_max) begin
          cnt_nx   = '0;
          state_nx = S_FAULT;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_RESP: begin
        ptr_nx   = ~gsel;
        state_nx = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clr) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decode straight from reset flops, so reset clears them at once.
  always_comb begin
    gnt      = '0;
    done     = '0;
    hit      = 1'b0;
    stage_in = '0;
    fault    = 1'b0;
    unique case (state)
      S_DATA: begin
        gnt      = gsel_oh;
        stage_in = vec_r;
      end
      S_NULL: gnt = gsel_oh;
      S_RESP: begin
        gnt  = gsel_oh;
        done = gsel_oh;
        hit  = hit_r;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

endmodule
